// File: rtl/peripheral_msi_master_port_bb.sv
// rtl/peripheral_msi_master_port_bb.sv - MSI AHB-Lite master port: address decode, grant stall, default ERROR slave
//
// Purpose:
//   One instance per AHB master. Decodes the master address phase against a
//   per-slave base/mask map, routes it to one of SLAVES slave ports, stalls the
//   master until the target slave port grants it, returns the selected data
//   phase response and answers unmapped transfers with a two-cycle ERROR.
//
// Ports:
//   HRESETn, HCLK               async active-low reset, clock
//   mstH*                       master-side address/data phase inputs
//   mstHRDATA/READYOUT/RESP     data phase response to the master
//   slvHADDRbase/mask           address map, one entry per slave port
//   slvHSEL                     one-hot select toward the slave ports
//   slvH* (addr/ctrl/wdata)     address/data broadcast toward all slave ports
//   slvHREADY                   HREADY toward the slave ports
//   slvHRDATA/READYOUT/RESP     per-slave-port responses
//   granted                     bit s: slave port s currently grants this master
//   can_switch                  bit s: slave port s may re-arbitrate away from us

module peripheral_msi_master_port_bb #(
  parameter int PLEN   = 64,
  parameter int XLEN   = 64,
  parameter int SLAVES = 5
) (
  input  logic                         HRESETn,
  input  logic                         HCLK,

  input  logic                         mstHSEL,
  input  logic [PLEN-1:0]              mstHADDR,
  input  logic [XLEN-1:0]              mstHWDATA,
  input  logic                         mstHWRITE,
  input  logic [2:0]                   mstHSIZE,
  input  logic [2:0]                   mstHBURST,
  input  logic [3:0]                   mstHPROT,
  input  logic [1:0]                   mstHTRANS,
  input  logic                         mstHMASTLOCK,
  input  logic                         mstHREADY,
  output logic [XLEN-1:0]              mstHRDATA,
  output logic                         mstHREADYOUT,
  output logic                         mstHRESP,

  input  logic [SLAVES-1:0][PLEN-1:0]  slvHADDRbase,
  input  logic [SLAVES-1:0][PLEN-1:0]  slvHADDRmask,

  output logic [SLAVES-1:0]            slvHSEL,
  output logic [PLEN-1:0]              slvHADDR,
  output logic [XLEN-1:0]              slvHWDATA,
  output logic                         slvHWRITE,
  output logic [2:0]                   slvHSIZE,
  output logic [2:0]                   slvHBURST,
  output logic [3:0]                   slvHPROT,
  output logic [1:0]                   slvHTRANS,
  output logic                         slvHMASTLOCK,
  output logic                         slvHREADY,
  input  logic [SLAVES-1:0][XLEN-1:0]  slvHRDATA,
  input  logic [SLAVES-1:0]            slvHREADYOUT,
  input  logic [SLAVES-1:0]            slvHRESP,

  input  logic [SLAVES-1:0]            granted,
  output logic [SLAVES-1:0]            can_switch
);

  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    WAIT_GRANT,
    ERR1,
    ERR2
  } state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     dsel, dsel_nxt;
  logic              latch_en;

  // address phase held while waiting for a grant
  logic [PLEN-1:0]   l_addr;
  logic              l_write;
  logic [2:0]        l_size;
  logic [2:0]        l_burst;
  logic [3:0]        l_prot;
  logic              l_lock;
  logic [SW-1:0]     l_sel;

  logic              dec_hit;
  logic [SW-1:0]     dec_idx;
  logic              accept;
  logic              in_wait;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if (((mstHADDR ^ slvHADDRbase[s]) & slvHADDRmask[s]) == '0) begin
        dec_hit = 1'b1;
        dec_idx = SW'(s);
      end
    end
  end

  assign accept  = mstHSEL & mstHTRANS[1] & mstHREADY & mstHREADYOUT;
  assign in_wait = (state == WAIT_GRANT);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      dsel    <= '0;
      l_addr  <= '0;
      l_write <= 1'b0;
      l_size  <= '0;
      l_burst <= '0;
      l_prot  <= '0;
      l_lock  <= 1'b0;
      l_sel   <= '0;
    end else begin
      state <= state_nxt;
      dsel  <= dsel_nxt;
      if (latch_en) begin
        l_addr  <= mstHADDR;
        l_write <= mstHWRITE;
        l_size  <= mstHSIZE;
        l_burst <= mstHBURST;
        l_prot  <= mstHPROT;
        l_lock  <= mstHMASTLOCK;
        l_sel   <= dec_idx;
      end
    end
  end

  // Next state plus master-side response.
  always_comb begin
    state_nxt    = state;
    dsel_nxt     = dsel;
    latch_en     = 1'b0;
    mstHREADYOUT = 1'b1;
    mstHRESP     = 1'b0;
    mstHRDATA    = '0;

    case (state)
      DATA: begin
        mstHRDATA    = slvHRDATA[dsel];
        mstHREADYOUT = slvHREADYOUT[dsel];
        mstHRESP     = slvHRESP[dsel];
      end
      WAIT_GRANT: begin
        mstHREADYOUT = 1'b0;
      end
      ERR1: begin
        mstHREADYOUT = 1'b0;
        mstHRESP     = 1'b1;
      end
      ERR2: begin
        mstHRESP     = 1'b1;
      end
      default: ;
    endcase

    case (state)
      WAIT_GRANT: begin
        // slave samples the held address phase in this same cycle
        if (granted[l_sel] & slvHREADYOUT[l_sel]) begin
          state_nxt = DATA;
          dsel_nxt  = l_sel;
        end
      end
      ERR1: state_nxt = ERR2;
      default: begin
        // IDLE, ERR2 and a completing DATA phase may take a new transfer
        if (mstHREADYOUT) begin
          if (!accept) begin
            state_nxt = IDLE;
          end else if (!dec_hit) begin
            state_nxt = ERR1;
          end else if (granted[dec_idx]) begin
            state_nxt = DATA;
            dsel_nxt  = dec_idx;
          end else begin
            state_nxt = WAIT_GRANT;
            latch_en  = 1'b1;
          end
        end
      end
    endcase
  end

  // Slave-side address path: pass-through, or replay of the held phase.
  always_comb begin
    slvHWDATA = mstHWDATA;
    if (in_wait) begin
      slvHSEL      = SLAVES'(1) << l_sel;
      slvHADDR     = l_addr;
      slvHWRITE    = l_write;
      slvHSIZE     = l_size;
      slvHBURST    = l_burst;
      slvHPROT     = l_prot;
      slvHTRANS    = HTRANS_NONSEQ;
      slvHMASTLOCK = l_lock;
      slvHREADY    = 1'b1;
    end else begin
      slvHSEL      = (mstHSEL & dec_hit) ? (SLAVES'(1) << dec_idx) : '0;
      slvHADDR     = mstHADDR;
      slvHWRITE    = mstHWRITE;
      slvHSIZE     = mstHSIZE;
      slvHBURST    = mstHBURST;
      slvHPROT     = mstHPROT;
      slvHTRANS    = mstHTRANS;
      slvHMASTLOCK = mstHMASTLOCK;
      slvHREADY    = mstHREADYOUT;
    end
  end

  // A locked transfer or a burst continuation (BUSY/SEQ, HTRANS[0]=1) pins the
  // slave currently addressed; slvHSEL already names that slave.
  assign can_switch = (mstHMASTLOCK | mstHTRANS[0]) ? ~slvHSEL : '1;

endmodule

// File: doc/peripheral_msi_master_port_bb.md
# peripheral_msi_master_port_bb

Master-side port of the MSI AHB-Lite interconnect: one per AHB master. It decodes the master's address phase against a per-slave base/mask map and routes it to one of SLAVES slave ports. It stalls the master while the target slave port has not yet granted it, returns the selected slave's data-phase response, and implements a two-cycle ERROR default slave for unmapped addresses. It also drives the per-slave `can_switch` flags that the slave-port arbiters consume.

## Interface
- PLEN, 64, address width
- XLEN, 64, data width
- SLAVES, 5, number of slave ports served
- HRESETn  in  1  asynchronous, active-low reset
- HCLK  in  1  clock
- mstHSEL, mstHWRITE, mstHMASTLOCK  in  1  master address-phase controls
- mstHADDR  in  PLEN; mstHWDATA  in  XLEN; mstHSIZE, mstHBURST  in  3; mstHPROT  in  4; mstHTRANS  in  2
- mstHREADY  in  1  bus HREADY seen by master
- mstHRDATA  out  XLEN; mstHREADYOUT  out  1; mstHRESP  out  1  data-phase response to master
- slvHADDRbase, slvHADDRmask  in  SLAVES×PLEN  address map; slave s matches when ((HADDR ^ base[s]) & mask[s]) == 0
- slvHSEL  out  SLAVES  one-hot select to slave ports
- slvHADDR  out  PLEN; slvHWDATA  out  XLEN; slvHWRITE  out  1; slvHSIZE, slvHBURST  out  3; slvHPROT  out  4; slvHTRANS  out  2; slvHMASTLOCK  out  1  broadcast address/data to all slave ports
- slvHREADY  out  1  HREADY toward slave ports
- slvHRDATA  in  SLAVES×XLEN; slvHREADYOUT, slvHRESP  in  SLAVES  per-slave-port responses
- granted  in  SLAVES  bit s = slave port s currently grants this master
- can_switch  out  SLAVES  bit s = slave port s may re-arbitrate away from this master

## Operation
- Decode: lowest-index matching slave wins. No match means the default slave.
- Accept: address phase accepted when mstHSEL & mstHTRANS[1] & mstHREADY & mstHREADYOUT. IDLE/BUSY transfers are never forwarded as errors.
- FSM states: IDLE, DATA, WAIT_GRANT, ERR1, ERR2.
- Transfer accepted from any state where mstHREADYOUT=1 (IDLE, DATA complete, ERR2):
  - Decoded slave s with granted[s]=1 → DATA. Data-phase index dsel<=s.
  - Decoded s with granted[s]=0 → WAIT_GRANT. Latch HADDR/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK and s.
  - No match → ERR1.
  - Nothing accepted → IDLE.
- IDLE and DATA, address path: master address-phase signals pass through combinationally. slvHSEL[s] = mstHSEL & match(s).
- WAIT_GRANT:
  - Slave bus is driven from latched registers. slvHSEL = onehot(s). slvHTRANS forced NONSEQ. slvHREADY=1.
  - mstHREADYOUT=0, mstHRESP=0.
  - Exit to DATA (dsel<=s) when granted[s] & slvHREADYOUT[s].
- DATA:
  - mstHRDATA=slvHRDATA[dsel], mstHREADYOUT=slvHREADYOUT[dsel], mstHRESP=slvHRESP[dsel].
  - Slave-side two-cycle ERROR is forwarded unchanged.
- ERR1: mstHREADYOUT=0, mstHRESP=1. Unconditionally → ERR2.
- ERR2: mstHREADYOUT=1, mstHRESP=1. Accepts the next transfer as above.
- IDLE: mstHREADYOUT=1, mstHRESP=0, mstHRDATA=0.
- slvHREADY = mstHREADYOUT, except =1 in WAIT_GRANT.
- slvHWDATA = mstHWDATA always. The slave port selects it by its own delayed index.
- can_switch[s] is 0 only when both hold:
  - the current address phase targets s (pass-through decode, or latched s in WAIT_GRANT);
  - mstHMASTLOCK=1 or mstHTRANS ∈ {BUSY, SEQ}.
  - Otherwise 1.

## Timing
- Reset (async) values: state=IDLE, dsel=0, latched regs=0. Outputs: mstHREADYOUT=1, mstHRESP=0, mstHRDATA=0, slvHSEL=0, slvHTRANS=IDLE, can_switch=all 1.
- Zero added latency when granted: slave sees the address phase in the same cycle as the master.
- Not granted: minimum one stall cycle. The slave address phase occurs in the cycle granted[s] & slvHREADYOUT[s] rise, and the data phase follows the next cycle.
- Default slave: ERROR completes exactly 2 cycles after acceptance (HREADYOUT low then high).
- Reset mid-transfer aborts without completing the response.
- granted[s] dropping during DATA has no effect. The data phase always completes on dsel.

## Test plan
- SLAVES=3, maps: s0 base 0x0/mask 0xF0000000, s1 base 0x10000000, s2 base 0x20000000. After reset, check mstHREADYOUT=1, mstHRESP=0, slvHSEL=000, can_switch=111.
- Granted read: granted=010, NONSEQ read 0x10000040 → slvHSEL=010 in the same cycle. Next cycle slvHRDATA[1]=0xCAFE with HREADYOUT high → mstHRDATA=0xCAFE, no stall.
- Ungranted write: granted=000, NONSEQ write 0x20000008 → WAIT_GRANT. mstHREADYOUT=0 for 3 cycles. Raise granted=100 → slvHSEL=100, HTRANS=NONSEQ, HADDR=0x20000008. Write completes one cycle later.
- Unmapped 0x30000000 → mstHREADYOUT/HRESP = 0/1, then 1/1, then idle 1/0.
- INCR4 to s0 with HMASTLOCK=0 → can_switch[0]=1 on NONSEQ, then 0 on each SEQ beat, then 1 after. With HMASTLOCK=1 → can_switch[0]=0 throughout.
- Assert HRESETn low during WAIT_GRANT → outputs return to reset values immediately. First post-reset transfer behaves normally.
